ledstrip_frame_arbiter: RTL and testbench
=========================================

Name: ledstrip_frame_arbiter

Overview:
- Shares the single ws2812b LED-strip driver between two frame sources:
  - port A: charmatrix renderer.
  - port B: status/test-pattern generator.
- Arbitrates only at frame boundaries, so a frame is never interleaved.
- Fetches pixels from the granted source via valid/ready and feeds them to the driver one at a time.
- Raises the driver latch for the strip reset gap, then re-arbitrates.

Parameters:
DATA_W, 24, pixel width (GRB).
CNT_W, 9, width of num_leds and the pixel counter.
LATCH_GAP_CYCLES, 1200, cycles of latch/idle after the last pixel (60 us at 20 MHz).

Ports:
clk  in  1  system clock (20 MHz).
rst_n  in  1  reset.
num_leds  in  CNT_W  pixels per frame; sampled at grant.
a_req  in  1  port A requests a frame (level).
a_grant  out  1  port A owns the current frame.
a_pix_valid  in  1  port A pixel valid.
a_pix_data  in  DATA_W  port A pixel.
a_pix_last  in  1  port A's final pixel of frame.
a_pix_ready  out  1  arbiter accepts a port A pixel.
b_req, b_grant, b_pix_valid, b_pix_data, b_pix_last, b_pix_ready: same as port A, for port B.
drv_data  out  DATA_W  pixel to driver.
drv_valid  out  1  start driver transmission.
drv_ready  in  1  driver idle; falls when transmission starts.
drv_latch  out  1  end-of-frame latch to driver.
frame_done  out  1  one-cycle pulse when the gap ends.
busy  out  1  high in any state except IDLE.

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n); all flops clear immediately on rst_n low.
- Reset values:
  - grants, pix_ready, drv_valid, drv_latch, frame_done, busy = 0.
  - drv_data = 0; pixel counter = 0; state = IDLE.
  - Round-robin pointer = "last granted B", so A wins the first tie.
- States: IDLE, FETCH, SEND, GAP.
- IDLE:
  - If num_leds != 0 and any req is high: pick winner, assert its grant next cycle, latch num_leds into frame_len, clear counter and pad flag, go to FETCH.
  - If num_leds == 0: requests are ignored; stay in IDLE.
- Arbitration:
  - Round-robin: if both requesters are high, the one not granted last wins.
  - If only one requester is high, it wins.
- FETCH:
  - pad flag clear: the granted port's pix_ready is high. On pix_valid & pix_ready, capture pix_data into drv_data, drop pix_ready next cycle, go to SEND. If pix_last is set and counter+1 < frame_len, set pad flag.
  - pad flag set: drv_data = 0, go to SEND in one cycle, no source handshake.
  - Granted req dropping mid-frame sets the pad flag. The frame always completes with zeros.
- SEND:
  - drv_valid is asserted only while drv_ready is high.
  - The first cycle with drv_valid=1 and drv_ready=0 is acceptance. On acceptance: drv_valid -> 0 and counter += 1.
  - If counter+1 == frame_len, go to GAP; else go to FETCH.
  - drv_data is held stable from capture until acceptance.
- Per-pixel latency when source and driver are both immediately ready: 3 cycles plus driver time.
- Source pixels beyond frame_len are never accepted, because grant drops at GAP entry.
  - A pix_last arriving exactly at frame_len is normal termination.
  - pix_last on the first pixel with frame_len = 1 is normal.
- GAP:
  - grant = 0 and drv_latch = 1 for exactly LATCH_GAP_CYCLES cycles.
  - Then drv_latch = 0, frame_done pulses for 1 cycle, return to IDLE.
  - A new grant can issue in the following cycle.
- num_leds changes mid-frame are ignored; frame_len is fixed at grant.
- Counter arithmetic is CNT_W-bit unsigned; frame_len up to 2^CNT_W-1 with no wrap.
- Reset mid-frame: driver sees drv_valid drop asynchronously. The partial frame is abandoned; the next frame restarts at pixel 0.

Optional Feature:
- Macro: LEDARB_FIXED_PRIO_EN.
- Defined: fixed priority. Port A always wins when both request; the round-robin pointer is removed.
- Undefined: round-robin as described above.

Test Plan:
- Single A frame, num_leds=3, LATCH_GAP_CYCLES=16, A pixels 0x0000FF, 0x00FF00, 0xFF0000 ->
  - driver accepts those 3 values in order.
  - drv_latch high for exactly 16 cycles, then frame_done pulses once.
  - b_grant stays 0 throughout.
- A and B requesting continuously, num_leds=2 -> grants alternate A,B,A,B over 4 frames. With LEDARB_FIXED_PRIO_EN -> A,A,A,A.
- Early last: num_leds=5, A sends 2 pixels (second with last=1) -> driver accepts 2 A pixels then 3× 0x000000; a_pix_ready stays 0 after the last pixel.
- Requester abort: B drops b_req after 1 of 4 pixels -> driver still receives 4 pixels, the final 3 being 0; then normal gap.
- Backpressure: drv_ready held low 50 cycles before the 2nd pixel -> drv_valid stays 0 during the stall, drv_data stable, no pixel lost or duplicated.
- Reset and config:
  - rst_n low mid-SEND of pixel 2 -> all outputs 0 immediately.
  - After release, the next frame starts at pixel 0 with the A-first tie rule.
  - num_leds=0 with a_req=1 -> no grant, busy=0.

Source files
------------

// File: rtl/ledstrip_frame_arbiter.sv
// rtl/ledstrip_frame_arbiter.sv - two-source frame arbiter in front of a single ws2812b strip driver
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   num_leds                           pixels per frame, sampled when a grant issues
//   a_req / b_req                      level frame requests from the two sources
//   a_grant / b_grant                  source owns the current frame
//   x_pix_valid/data/last, x_pix_ready pixel handshake with each source
//   drv_data, drv_valid, drv_ready     pixel hand-off to the strip driver
//   drv_latch                          strip reset gap after the last pixel
//   frame_done                         one-cycle pulse when the gap ends
//   busy                               arbiter is not idle
//
// Build option: define LEDARB_FIXED_PRIO_EN for fixed priority (port A wins ties);
// otherwise ties are resolved round-robin.

module ledstrip_frame_arbiter #(
    parameter int DATA_W           = 24,
    parameter int CNT_W            = 9,
    parameter int LATCH_GAP_CYCLES = 1200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CNT_W-1:0]  num_leds,
    input  logic              a_req,
    output logic              a_grant,
    input  logic              a_pix_valid,
    input  logic [DATA_W-1:0] a_pix_data,
    input  logic              a_pix_last,
    output logic              a_pix_ready,
    input  logic              b_req,
    output logic              b_grant,
    input  logic              b_pix_valid,
    input  logic [DATA_W-1:0] b_pix_data,
    input  logic              b_pix_last,
    output logic              b_pix_ready,
    output logic [DATA_W-1:0] drv_data,
    output logic              drv_valid,
    input  logic              drv_ready,
    output logic              drv_latch,
    output logic              frame_done,
    output logic              busy
);

    localparam int GAP_W = $clog2(LATCH_GAP_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, FETCH, SEND, GAP} state_t;

    state_t             state, state_nxt;
    logic               sel_b;      // granted port: 0 = A, 1 = B
    logic               pad;        // remaining pixels of this frame are sent as zero
    logic [CNT_W-1:0]   frame_len;
    logic [CNT_W-1:0]   pix_cnt;
    logic [GAP_W-1:0]   gap_cnt;

`ifndef LEDARB_FIXED_PRIO_EN
    logic               last_b;     // last granted port was B
`endif

    logic               owned;
    logic               cur_req, cur_valid, cur_last;
    logic [DATA_W-1:0]  cur_data;
    logic [CNT_W-1:0]   cnt_inc;
    logic               pick_b, start, accept, gap_end;

    assign owned     = (state == FETCH) || (state == SEND);
    assign cur_req   = sel_b ? b_req       : a_req;
    assign cur_valid = sel_b ? b_pix_valid : a_pix_valid;
    assign cur_last  = sel_b ? b_pix_last  : a_pix_last;
    assign cur_data  = sel_b ? b_pix_data  : a_pix_data;
    assign cnt_inc   = pix_cnt + 1'b1;

`ifdef LEDARB_FIXED_PRIO_EN
    assign pick_b = !a_req;
`else
    // On a tie the port that did not own the previous frame wins.
    assign pick_b = b_req && (!a_req || !last_b);
`endif

    assign start   = (state == IDLE) && (num_leds != '0) && (a_req || b_req);
    // The driver drops drv_ready when it picks up drv_valid; that cycle is the acceptance.
    assign accept  = (state == SEND) && drv_valid && !drv_ready;
    assign gap_end = (state == GAP) && (gap_cnt == GAP_W'(LATCH_GAP_CYCLES - 1));

    always_comb begin
        state_nxt   = state;
        a_grant     = owned && !sel_b;
        b_grant     = owned && sel_b;
        a_pix_ready = (state == FETCH) && !pad && !sel_b;
        b_pix_ready = (state == FETCH) && !pad && sel_b;
        drv_latch   = (state == GAP);
        busy        = (state != IDLE);
        case (state)
            IDLE:    if (start) state_nxt = FETCH;
            FETCH:   if (pad || cur_valid) state_nxt = SEND;
            SEND:    if (accept) state_nxt = (cnt_inc == frame_len) ? GAP : FETCH;
            GAP:     if (gap_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sel_b      <= 1'b0;
            pad        <= 1'b0;
            frame_len  <= '0;
            pix_cnt    <= '0;
            gap_cnt    <= '0;
            drv_data   <= '0;
            drv_valid  <= 1'b0;
            frame_done <= 1'b0;
`ifndef LEDARB_FIXED_PRIO_EN
            last_b     <= 1'b1;
`endif
        end else begin
            state      <= state_nxt;
            frame_done <= gap_end;
            case (state)
                IDLE: begin
                    if (start) begin
                        sel_b     <= pick_b;
                        frame_len <= num_leds;
                        pix_cnt   <= '0;
                        pad       <= 1'b0;
`ifndef LEDARB_FIXED_PRIO_EN
                        last_b    <= pick_b;
`endif
                    end
                end
                FETCH: begin
                    if (pad) begin
                        drv_data <= '0;
                    end else begin
                        if (cur_valid) begin
                            drv_data <= cur_data;
                            // Source finished early: fill the rest of the frame with zeros.
                            if (cur_last && (cnt_inc < frame_len)) pad <= 1'b1;
                        end
                        if (!cur_req) pad <= 1'b1;
                    end
                end
                SEND: begin
                    if (accept) begin
                        drv_valid <= 1'b0;
                        pix_cnt   <= cnt_inc;
                        gap_cnt   <= '0;
                    end else begin
                        drv_valid <= drv_ready;
                    end
                    if (!cur_req) pad <= 1'b1;
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ledstrip_frame_arbiter.sv
// tb/tb_ledstrip_frame_arbiter.sv - scoreboard bench for ledstrip_frame_arbiter
module tb_ledstrip_frame_arbiter;

    localparam int DW    = 24;
    localparam int CW    = 9;
    localparam int GAP   = 16;
    localparam int DRV_T = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] num_leds = '0;
    logic          a_req = 1'b0, b_req = 1'b0;
    logic          a_grant, b_grant;
    logic          a_pix_valid = 1'b0, b_pix_valid = 1'b0;
    logic [DW-1:0] a_pix_data = '0, b_pix_data = '0;
    logic          a_pix_last = 1'b0, b_pix_last = 1'b0;
    logic          a_pix_ready, b_pix_ready;
    logic [DW-1:0] drv_data;
    logic          drv_valid;
    logic          drv_ready = 1'b1;
    logic          drv_latch, frame_done, busy;

    always #5 clk = ~clk;

    ledstrip_frame_arbiter #(.DATA_W(DW), .CNT_W(CW), .LATCH_GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .num_leds(num_leds),
        .a_req(a_req), .a_grant(a_grant), .a_pix_valid(a_pix_valid), .a_pix_data(a_pix_data),
        .a_pix_last(a_pix_last), .a_pix_ready(a_pix_ready),
        .b_req(b_req), .b_grant(b_grant), .b_pix_valid(b_pix_valid), .b_pix_data(b_pix_data),
        .b_pix_last(b_pix_last), .b_pix_ready(b_pix_ready),
        .drv_data(drv_data), .drv_valid(drv_valid), .drv_ready(drv_ready),
        .drv_latch(drv_latch), .frame_done(frame_done), .busy(busy)
    );

    int n_cmp = 0, n_err = 0;
    logic [DW-1:0] exp_pix[$];
    bit            exp_gnt[$];
    logic [DW:0]   a_q[$], b_q[$];
    int a_pops = 0, b_pops = 0, drv_count = 0, n_grants = 0;
    int stall_at = -1;
    bit stall_check = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // 0: drv_latch, 1: frame_done, 2: a_pops>=arg, 3: b_pops>=arg, else n_grants>=arg
    task automatic wait_until(input int which, input int arg, input string name);
        int t;
        bit ok;
        t = 0;
        forever begin
            @(negedge clk);
            case (which)
                0:       ok = drv_latch;
                1:       ok = frame_done;
                2:       ok = (a_pops >= arg);
                3:       ok = (b_pops >= arg);
                default: ok = (n_grants >= arg);
            endcase
            if (ok) break;
            t++;
            if (t > 2000) begin
                n_cmp++; n_err++;
                $display("FAIL timeout_%s: condition not seen within 2000 cycles", name);
                break;
            end
        end
    endtask

    task automatic frame_end(input string name);
        wait_until(0, 0, {name, "_latch"});
        a_req = 1'b0;
        b_req = 1'b0;
        wait_until(1, 0, {name, "_done"});
    endtask

    // Source models: present the head of each queue, pop on handshake.
    initial begin : src
        bit ah, bh;
        forever begin
            @(negedge clk);
            ah = a_pix_valid && a_pix_ready;
            bh = b_pix_valid && b_pix_ready;
            @(posedge clk);
            #1;
            if (ah && a_q.size() > 0) begin a_q.delete(0); a_pops++; end
            if (bh && b_q.size() > 0) begin b_q.delete(0); b_pops++; end
            a_pix_valid = (a_q.size() > 0);
            b_pix_valid = (b_q.size() > 0);
            {a_pix_last, a_pix_data} = (a_q.size() > 0) ? a_q[0] : '0;
            {b_pix_last, b_pix_data} = (b_q.size() > 0) ? b_q[0] : '0;
        end
    end

    // Driver model and pixel monitor.
    initial begin : drv
        logic [DW-1:0] held;
        int hold, bad, chg;
        bit stall;
        forever begin
            @(negedge clk);
            if (rst_n && drv_ready && drv_valid) begin
                if (exp_pix.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL drv_pixel: got unexpected %0h expected none", drv_data);
                end else begin
                    chk("drv_pixel", 32'(drv_data), 32'(exp_pix.pop_front()));
                end
                stall = (drv_count == stall_at);
                hold  = stall ? 50 : DRV_T;
                drv_count++;
                @(posedge clk);
                #1 drv_ready = 1'b0;
                @(posedge clk);
                bad = 0; chg = 0; held = '0;
                for (int i = 1; i < hold; i++) begin
                    @(negedge clk);
                    if (stall && stall_check) begin
                        if (drv_valid) bad++;
                        if (i == 20) held = drv_data;
                        if (i > 20 && drv_data !== held) chg++;
                    end
                end
                if (stall && stall_check) begin
                    chk("stall_valid_low", 32'(bad), 32'd0);
                    chk("stall_data_stable", 32'(chg), 32'd0);
                end
                @(posedge clk);
                #1 drv_ready = 1'b1;
            end
        end
    end

    // Grant monitor: each new ownership pops the expected port.
    initial begin : gmon
        bit pg, g;
        pg = 1'b0;
        forever begin
            @(negedge clk);
            g = a_grant || b_grant;
            if (g && !pg) begin
                n_grants++;
                if (exp_gnt.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL grant_port: got grant b=%0d expected none", b_grant);
                end else begin
                    chk("grant_port", 32'(b_grant), 32'(exp_gnt.pop_front()));
                end
            end
            pg = g;
        end
    end

    // Latch-length monitor, checked at every frame_done.
    initial begin : lmon
        int lc;
        lc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) lc = 0;
            else if (drv_latch) lc++;
            if (frame_done) begin
                chk("latch_len", 32'(lc), 32'(GAP));
                lc = 0;
            end
        end
    end

    initial begin : main
        int p0, g0, rc, t, bad;
        repeat (3) @(negedge clk);
        chk("rst_a_grant", 32'(a_grant), 32'd0);
        chk("rst_b_grant", 32'(b_grant), 32'd0);
        chk("rst_a_ready", 32'(a_pix_ready), 32'd0);
        chk("rst_b_ready", 32'(b_pix_ready), 32'd0);
        chk("rst_drv_valid", 32'(drv_valid), 32'd0);
        chk("rst_drv_latch", 32'(drv_latch), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_drv_data", 32'(drv_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single A frame of three pixels.
        num_leds = 9'd3;
        a_q.push_back({1'b0, 24'h0000FF});
        a_q.push_back({1'b0, 24'h00FF00});
        a_q.push_back({1'b1, 24'hFF0000});
        exp_gnt.push_back(1'b0);
        exp_pix.push_back(24'h0000FF);
        exp_pix.push_back(24'h00FF00);
        exp_pix.push_back(24'hFF0000);
        a_req = 1'b1;
        frame_end("single_a");

        // B aborts after one of four pixels: rest padded with zeros.
        num_leds = 9'd4;
        b_q.push_back({1'b0, 24'h111111});
        b_q.push_back({1'b0, 24'h222222});
        b_q.push_back({1'b0, 24'h333333});
        b_q.push_back({1'b1, 24'h444444});
        exp_gnt.push_back(1'b1);
        exp_pix.push_back(24'h111111);
        repeat (3) exp_pix.push_back(24'h000000);
        p0 = b_pops;
        b_req = 1'b1;
        wait_until(3, p0 + 1, "abort_first_pix");
        b_req = 1'b0;
        b_q.delete();
        wait_until(0, 0, "abort_latch");
        wait_until(1, 0, "abort_done");

        // Both requesting for four frames of two pixels.
        num_leds = 9'd2;
        for (int k = 0; k < 8; k++) begin
            a_q.push_back({k[0], 24'(24'hA00000 + k)});
            b_q.push_back({k[0], 24'(24'hB00000 + k)});
        end
        for (int f = 0; f < 4; f++) begin
`ifdef LEDARB_FIXED_PRIO_EN
            exp_gnt.push_back(1'b0);
            exp_pix.push_back(24'(24'hA00000 + 2 * f));
            exp_pix.push_back(24'(24'hA00000 + 2 * f + 1));
`else
            exp_gnt.push_back(f[0]);
            exp_pix.push_back(24'((f[0] ? 24'hB00000 : 24'hA00000) + 2 * (f / 2)));
            exp_pix.push_back(24'((f[0] ? 24'hB00000 : 24'hA00000) + 2 * (f / 2) + 1));
`endif
        end
        g0 = n_grants;
        a_req = 1'b1;
        b_req = 1'b1;
        wait_until(4, g0 + 4, "rr_four_grants");
        frame_end("rr");
        a_q.delete();
        b_q.delete();

        // Early last: 2 real pixels, then 3 zero pixels, no further A handshakes.
        num_leds = 9'd5;
        a_q.push_back({1'b0, 24'h123456});
        a_q.push_back({1'b1, 24'h654321});
        exp_gnt.push_back(1'b0);
        exp_pix.push_back(24'h123456);
        exp_pix.push_back(24'h654321);
        repeat (3) exp_pix.push_back(24'h000000);
        p0 = a_pops;
        a_req = 1'b1;
        wait_until(2, p0 + 2, "early_last_pix");
        rc = 0; t = 0;
        while (!drv_latch) begin
            @(negedge clk);
            if (a_pix_ready) rc++;
            t++;
            if (t > 2000) begin
                n_cmp++; n_err++;
                $display("FAIL timeout_early_last_latch: latch not seen within 2000 cycles");
                break;
            end
        end
        chk("ready_after_last", 32'(rc), 32'd0);
        a_req = 1'b0;
        wait_until(1, 0, "early_last_done");

        // Driver backpressure for 50 cycles before the second pixel.
        num_leds = 9'd3;
        a_q.push_back({1'b0, 24'hC0FFEE});
        a_q.push_back({1'b0, 24'hBEEF01});
        a_q.push_back({1'b1, 24'h00ABCD});
        exp_gnt.push_back(1'b0);
        exp_pix.push_back(24'hC0FFEE);
        exp_pix.push_back(24'hBEEF01);
        exp_pix.push_back(24'h00ABCD);
        stall_at = drv_count;
        stall_check = 1'b1;
        a_req = 1'b1;
        frame_end("backpressure");
        stall_check = 1'b0;

        // Reset while the second pixel waits in SEND.
        num_leds = 9'd4;
        a_q.push_back({1'b0, 24'hD00001});
        a_q.push_back({1'b0, 24'hD00002});
        a_q.push_back({1'b0, 24'hD00003});
        a_q.push_back({1'b1, 24'hD00004});
        exp_gnt.push_back(1'b0);
        exp_pix.push_back(24'hD00001);
        stall_at = drv_count;
        p0 = a_pops;
        a_req = 1'b1;
        wait_until(2, p0 + 2, "reset_second_pix");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_a_grant", 32'(a_grant), 32'd0);
        chk("mid_rst_a_ready", 32'(a_pix_ready), 32'd0);
        chk("mid_rst_drv_valid", 32'(drv_valid), 32'd0);
        chk("mid_rst_drv_data", 32'(drv_data), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_latch", 32'(drv_latch), 32'd0);
        a_req = 1'b0;
        a_q.delete();
        stall_at = -1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // After reset, a tie goes to A and the frame starts from pixel 0.
        num_leds = 9'd2;
        a_q.push_back({1'b0, 24'hE00001});
        a_q.push_back({1'b1, 24'hE00002});
        b_q.push_back({1'b0, 24'hF00001});
        b_q.push_back({1'b1, 24'hF00002});
        exp_gnt.push_back(1'b0);
        exp_pix.push_back(24'hE00001);
        exp_pix.push_back(24'hE00002);
        a_req = 1'b1;
        b_req = 1'b1;
        frame_end("post_reset");
        b_q.delete();

        // Zero-length frames are never granted.
        num_leds = 9'd0;
        a_req = 1'b1;
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (a_grant || b_grant || busy) bad++;
        end
        chk("zero_len_idle", 32'(bad), 32'd0);
        a_req = 1'b0;

        repeat (5) @(negedge clk);
        chk("pix_queue_empty", 32'(exp_pix.size()), 32'd0);
        chk("grant_queue_empty", 32'(exp_gnt.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
